// File: rtl/seq_det_rr_sched_if.sv
// Channel-side bundle for seq_det_rr_sched: per-channel serial handshake plus grant/detect status.
// The producer side drives valid/bit/clr; the scheduler side returns grant, detect and debug state.
interface seq_det_rr_sched_if #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 8
) ();

    logic [N_CH-1:0]   ch_valid;
    logic [N_CH-1:0]   ch_bit;
    logic [N_CH-1:0]   ch_clr;
    logic [N_CH-1:0]   ch_ready;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [N_CH-1:0]   det;
    logic [CNT_W-1:0]  det_cnt;
    logic [2*N_CH-1:0] cs_dbg;

    modport master (
        output ch_valid, ch_bit, ch_clr,
        input  ch_ready, grant_vld, grant_id, det, det_cnt, cs_dbg
    );

    modport slave (
        input  ch_valid, ch_bit, ch_clr,
        output ch_ready, grant_vld, grant_id, det, det_cnt, cs_dbg
    );

endinterface

// File: rtl/seq_det_rr_sched.sv
// Round-robin time-shared "1010" Mealy detector serving N_CH serial channels with per-channel contexts.
// Define SEQ_DET_OVERLAP_EN for overlapping detection (s101 + 0 -> s10); default is non-overlapping.
module seq_det_rr_sched #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned CNT_W = 8
) (
    input logic              clk,
    input logic              rst_n,
    seq_det_rr_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } det_state_e;

    det_state_e        ctx_q [N_CH];
    det_state_e        ctx_d [N_CH];
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_CH-1:0]   det_q, det_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   ready;
    logic              gvld;
    logic [ID_W-1:0]   gid;
    int unsigned       idx;

    det_state_e        cur_st, nxt_st;
    logic              cur_bit;
    logic              hit;
    logic [2*N_CH-1:0] cs_flat;

    // Arbiter: first requester at or after ptr+1, wrapping; a channel being cleared never requests
    always_comb begin
        req   = bus.ch_valid & ~bus.ch_clr;
        ready = '0;
        gvld  = 1'b0;
        gid   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= N_CH; k++) begin
            idx = (32'(ptr_q) + k) % N_CH;
            if (!gvld && req[ID_W'(idx)]) begin
                gvld = 1'b1;
                gid  = ID_W'(idx);
            end
        end
        if (gvld) begin
            ready[gid] = 1'b1;
        end
    end

    // Shared detector next-state/hit logic on the granted channel's context
    always_comb begin
        cur_st  = ctx_q[gid];
        cur_bit = bus.ch_bit[gid];
        nxt_st  = cur_st;
        hit     = 1'b0;
        case (cur_st)
            S0:   nxt_st = cur_bit ? S1 : S0;
            S1:   nxt_st = cur_bit ? S1 : S10;
            S10:  nxt_st = cur_bit ? S101 : S0;
            S101: begin
                if (cur_bit) begin
                    nxt_st = S1;
                end else begin
                    hit = 1'b1;
`ifdef SEQ_DET_OVERLAP_EN
                    nxt_st = S10;
`else
                    nxt_st = S0;
`endif
                end
            end
            default: nxt_st = S0;
        endcase
    end

    // Next-state for pointer, contexts, detect pulses and saturating counter
    always_comb begin
        ptr_d = ptr_q;
        det_d = '0;
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            ctx_d[i] = ctx_q[i];
        end
        if (gvld) begin
            ptr_d      = gid;
            ctx_d[gid] = nxt_st;
            det_d[gid] = hit;
            if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Clear wins over any other update of the channel
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (bus.ch_clr[i]) begin
                ctx_d[i] = S0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                ctx_q[i] <= S0;
            end
            ptr_q <= ID_W'(N_CH - 1);
            det_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                ctx_q[i] <= ctx_d[i];
            end
            ptr_q <= ptr_d;
            det_q <= det_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cs_flat = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cs_flat[2*i +: 2] = ctx_q[i];
        end
    end

    assign bus.ch_ready  = ready;
    assign bus.grant_vld = gvld;
    assign bus.grant_id  = gid;
    assign bus.det       = det_q;
    assign bus.det_cnt   = cnt_q;
    assign bus.cs_dbg    = cs_flat;

endmodule

// File: tb/tb_seq_det_rr_sched.sv
// Directed vector bench for seq_det_rr_sched (N_CH=4); a second CNT_W=2 instance shares stimulus for saturation.
module tb_seq_det_rr_sched;

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif
    localparam logic [7:0] K = 8'd5 + 8'(OVL);

    typedef struct {
        logic [3:0] v;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] rdy;
        logic       gv;
        logic [1:0] gid;
        logic [3:0] det;
        logic [7:0] cnt;
        logic [7:0] cs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    seq_det_rr_sched_if #(.N_CH(4), .ID_W(2), .CNT_W(8)) bus ();
    seq_det_rr_sched_if #(.N_CH(4), .ID_W(2), .CNT_W(2)) bus_s ();

    assign bus_s.ch_valid = bus.ch_valid;
    assign bus_s.ch_bit   = bus.ch_bit;
    assign bus_s.ch_clr   = bus.ch_clr;

    seq_det_rr_sched #(.N_CH(4), .ID_W(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seq_det_rr_sched #(.N_CH(4), .ID_W(2), .CNT_W(2)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    function automatic vec_t mk(input logic [3:0] v, b, c, rdy, input logic gv,
                                input logic [1:0] gid, input logic [3:0] det,
                                input logic [7:0] cnt, cs);
        vec_t t;
        t.v = v; t.b = b; t.c = c; t.rdy = rdy; t.gv = gv;
        t.gid = gid; t.det = det; t.cnt = cnt; t.cs = cs;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    // Comb outputs checked mid-cycle, registered outputs just after the consuming edge
    task automatic step(input vec_t t, input string tag);
        bus.ch_valid = t.v;
        bus.ch_bit   = t.b;
        bus.ch_clr   = t.c;
        @(negedge clk);
        chk({tag, ".ready"}, 32'(bus.ch_ready), 32'(t.rdy));
        chk({tag, ".gvld"},  32'(bus.grant_vld), 32'(t.gv));
        chk({tag, ".gid"},   32'(bus.grant_id), 32'(t.gid));
        @(posedge clk);
        #1;
        chk({tag, ".det"},   32'(bus.det), 32'(t.det));
        chk({tag, ".cnt"},   32'(bus.det_cnt), 32'(t.cnt));
        chk({tag, ".cs"},    32'(bus.cs_dbg), 32'(t.cs));
    endtask

    initial begin
        // Fairness: all channels stream 1010, one bit per channel per 4 cycles
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'd0, 8'h01));
        tbl.push_back(mk(4'b1111, 4'b1110, 4'b0000, 4'b0010, 1, 1, 4'b0000, 8'd0, 8'h05));
        tbl.push_back(mk(4'b1111, 4'b1100, 4'b0000, 4'b0100, 1, 2, 4'b0000, 8'd0, 8'h15));
        tbl.push_back(mk(4'b1111, 4'b1000, 4'b0000, 4'b1000, 1, 3, 4'b0000, 8'd0, 8'h55));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'd0, 8'h56));
        tbl.push_back(mk(4'b1111, 4'b0001, 4'b0000, 4'b0010, 1, 1, 4'b0000, 8'd0, 8'h5A));
        tbl.push_back(mk(4'b1111, 4'b0011, 4'b0000, 4'b0100, 1, 2, 4'b0000, 8'd0, 8'h6A));
        tbl.push_back(mk(4'b1111, 4'b0111, 4'b0000, 4'b1000, 1, 3, 4'b0000, 8'd0, 8'hAA));
        tbl.push_back(mk(4'b1111, 4'b1111, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'd0, 8'hAB));
        tbl.push_back(mk(4'b1111, 4'b1110, 4'b0000, 4'b0010, 1, 1, 4'b0000, 8'd0, 8'hAF));
        tbl.push_back(mk(4'b1111, 4'b1100, 4'b0000, 4'b0100, 1, 2, 4'b0000, 8'd0, 8'hBF));
        tbl.push_back(mk(4'b1111, 4'b1000, 4'b0000, 4'b1000, 1, 3, 4'b0000, 8'd0, 8'hFF));
        tbl.push_back(mk(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0001, 8'd1, OVL ? 8'hFE : 8'hFC));
        tbl.push_back(mk(4'b1110, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0010, 8'd2, OVL ? 8'hFA : 8'hF0));
        tbl.push_back(mk(4'b1100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 4'b0100, 8'd3, OVL ? 8'hEA : 8'hC0));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 3, 4'b1000, 8'd4, OVL ? 8'hAA : 8'h00));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 8'd4, OVL ? 8'hAA : 8'h00));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 4'b0000, 8'd4, 8'h00));
        // Single channel 1,0,1,0,1,0 (overlap dependent)
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'd4, 8'h01));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'd4, 8'h02));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'd4, 8'h03));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0001, 8'd5, OVL ? 8'h02 : 8'h00));
        tbl.push_back(mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'd5, OVL ? 8'h03 : 8'h01));
        tbl.push_back(mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, OVL ? 4'b0001 : 4'b0000, K, 8'h02));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, K, 8'h02));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0000, K, 8'h00));
        // Interleaving: ch1 partial, ch2 full sequence, ch1 completes
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 1, 4'b0000, K, 8'h04));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0000, K, 8'h08));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2, 4'b0000, K, 8'h18));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 4'b0000, K, 8'h28));
        tbl.push_back(mk(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2, 4'b0000, K, 8'h38));
        tbl.push_back(mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2, 4'b0100, K + 8'd1, OVL ? 8'h28 : 8'h08));
        tbl.push_back(mk(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 1, 4'b0000, K + 8'd1, OVL ? 8'h2C : 8'h0C));
        tbl.push_back(mk(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 1, 4'b0010, K + 8'd2, OVL ? 8'h28 : 8'h00));
        // Clear with simultaneous valid: ch3 at s101 is not granted, ch0 is
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0, 4'b0000, K + 8'd2, 8'h00));
        tbl.push_back(mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, 3, 4'b0000, K + 8'd2, 8'h40));
        tbl.push_back(mk(4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 3, 4'b0000, K + 8'd2, 8'h80));
        tbl.push_back(mk(4'b1000, 4'b1000, 4'b0000, 4'b1000, 1, 3, 4'b0000, K + 8'd2, 8'hC0));
        tbl.push_back(mk(4'b1001, 4'b0001, 4'b1000, 4'b0001, 1, 0, 4'b0000, K + 8'd2, 8'h01));
        tbl.push_back(mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0000, K + 8'd2, 8'h00));

        rst_n        = 1'b0;
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        bus.ch_clr   = '0;
        #12;
        chk("rst.ready", 32'(bus.ch_ready), 32'd0);
        chk("rst.gvld",  32'(bus.grant_vld), 32'd0);
        chk("rst.gid",   32'(bus.grant_id), 32'd0);
        chk("rst.det",   32'(bus.det), 32'd0);
        chk("rst.cnt",   32'(bus.det_cnt), 32'd0);
        chk("rst.cs",    32'(bus.cs_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Reset mid-stream: partial context and counter cleared without waiting for an edge
        step(mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, K + 8'd2, 8'h01), "mrst.a");
        step(mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, K + 8'd2, 8'h02), "mrst.b");
        step(mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, K + 8'd2, 8'h03), "mrst.c");
        bus.ch_valid = '0;
        bus.ch_bit   = '0;
        rst_n        = 1'b0;
        #1;
        chk("mrst.cnt", 32'(bus.det_cnt), 32'd0);
        chk("mrst.cs",  32'(bus.cs_dbg), 32'd0);
        chk("mrst.det", 32'(bus.det), 32'd0);
        chk("mrst.sat_cnt", 32'(bus_s.det_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturation on the CNT_W=2 instance: five detections on ch0
        for (int n = 1; n <= 5; n++) begin
            step(mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'(n - 1), 8'h01), $sformatf("sat%0d.b1", n));
            step(mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'(n - 1), 8'h02), $sformatf("sat%0d.b2", n));
            step(mk(4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 0, 4'b0000, 8'(n - 1), 8'h03), $sformatf("sat%0d.b3", n));
            step(mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 4'b0001, 8'(n), OVL ? 8'h02 : 8'h00), $sformatf("sat%0d.b4", n));
            chk($sformatf("sat%0d.sdet", n), 32'(bus_s.det), 32'd1);
            chk($sformatf("sat%0d.scnt", n), 32'(bus_s.det_cnt), (n < 3) ? 32'(n) : 32'd3);
            step(mk(4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 4'b0000, 8'(n), 8'h00), $sformatf("sat%0d.clr", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
